// File: rtl/instr_loader.sv
// Byte-stream program loader: packs 4 bytes little-endian per word, writes
// consecutive instruction-memory words and holds the CPU in reset until done.
module instr_loader #(
  parameter int unsigned WORD_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WORD_AW:0]   num_words_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_in_i,
  output logic               byte_ready_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        mem_wd_o,
  output logic               cpu_hold_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned CNT_W = WORD_AW + 1;
  localparam logic [WORD_AW:0] MAX_WORDS = {1'b1, {WORD_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [WORD_AW:0] idx_q, idx_d;
  logic [WORD_AW:0] nw_q, nw_d;
  logic             ready_q, ready_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wd_q, wd_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             take_byte;
  logic [WORD_AW:0] idx_inc;

  assign take_byte = ready_q && byte_valid_i;
  assign idx_inc   = idx_q + CNT_W'(1);

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      bcnt_q  <= 2'd0;
      shift_q <= 24'd0;
      idx_q   <= '0;
      nw_q    <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wd_q    <= 32'd0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      nw_q    <= nw_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    nw_d    = nw_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((num_words_i != '0) && (num_words_i <= MAX_WORDS)) begin
            nw_d    = num_words_i;
            idx_d   = '0;
            bcnt_d  = 2'd0;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = S_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (take_byte) begin
          if (bcnt_q == 2'd3) begin
            // Fourth byte goes straight into the word; it never lands in shift_q
            wd_d    = {byte_in_i, shift_q};
            addr_d  = BASE_ADDR + 32'({idx_q[WORD_AW-1:0], 2'b00});
            bcnt_d  = 2'd0;
            state_d = S_WRITE;
          end else begin
            shift_d[{bcnt_q, 3'b000} +: 8] = byte_in_i;
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == nw_q) begin
          hold_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          state_d = S_RECV;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_RECV);
    we_d    = (state_d == S_WRITE);
    done_d  = (state_d == S_FIN);
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wd_o     = wd_q;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
